// File: rtl/etapa_mem.sv
// Memory-access stage between EX_MEM and MEM_WB: byte/half/word loads and stores with
// LATENCIA wait states and an upstream stall. Optional macro: ALINEACION_CHECK_EN.
module etapa_mem #(
  parameter int ANCHO_DIR = 10,
  parameter int LATENCIA  = 2
) (
  input  logic        clk,
  input  logic        reinicio_n,
  input  logic        valido_entrada,
  input  logic        lee_mem,
  input  logic        escribe_mem,
  input  logic [1:0]  tamano,
  input  logic        sin_signo,
  input  logic [31:0] resultado_alu_entrada,
  input  logic [31:0] dato_escritura,
  input  logic [4:0]  registro_destino_entrada,
  output logic        detener,
  output logic        valido_salida,
  output logic [31:0] resultado_alu_salida,
  output logic [31:0] dato_mem_salida,
  output logic [4:0]  registro_destino_salida,
  output logic        error_alineacion,
  output logic [1:0]  estado_dbg
);

  // Handshake: an instruction is taken from EX_MEM on a rising edge where the stage is
  // in REPOSO and valido_entrada=1; upstream must hold while detener=1, and
  // valido_salida is a single-cycle strobe with no back-pressure from MEM_WB.

  typedef enum logic [1:0] {
    REPOSO = 2'd0,
    ACCESO = 2'd1,
    FIN    = 2'd2
  } estado_t;

  estado_t estado, estado_sig;
  logic [3:0]  cnt;

  logic        cap_lee, cap_esc, cap_sig;
  logic [1:0]  cap_tam;
  logic [31:0] cap_alu, cap_dato;
  logic [4:0]  cap_rd;

  logic        es_memop, desal, acepta, commit;
  logic [ANCHO_DIR-1:0] indice;
  logic [31:0] palabra, desp_byte, desp_media, carga, wdat;
  logic [3:0]  be;

  logic [31:0] mem [0:(2**ANCHO_DIR)-1];

  assign es_memop = valido_entrada & (lee_mem | escribe_mem);

`ifdef ALINEACION_CHECK_EN
  always_comb begin
    desal = 1'b0;
    case (tamano)
      2'b00:   desal = 1'b0;
      2'b01:   desal = resultado_alu_entrada[0];
      default: desal = |resultado_alu_entrada[1:0];
    endcase
  end
`else
  // Misaligned half/word accesses are silently forced aligned by the lane logic.
  assign desal = 1'b0;
`endif

  assign acepta     = (estado == REPOSO) & es_memop & ~desal;
  assign commit     = (estado == ACCESO) & (cnt == 4'd0);
  assign estado_dbg = estado;

  always_comb begin
    estado_sig = estado;
    detener    = 1'b0;
    case (estado)
      REPOSO: begin
        if (acepta) begin
          detener    = 1'b1;
          estado_sig = ACCESO;
        end
      end
      ACCESO: begin
        detener = 1'b1;
        if (cnt == 4'd0) estado_sig = FIN;
      end
      FIN:     estado_sig = REPOSO;
      default: estado_sig = REPOSO;
    endcase
  end

  // Word index wraps: address bits above ANCHO_DIR+1 are ignored.
  assign indice  = cap_alu[ANCHO_DIR+1:2];
  assign palabra = mem[indice];

  always_comb begin
    be   = 4'b0000;
    wdat = {4{cap_dato[7:0]}};
    case (cap_tam)
      2'b00: be = 4'b0001 << cap_alu[1:0];
      2'b01: begin
        be   = cap_alu[1] ? 4'b1100 : 4'b0011;
        wdat = {2{cap_dato[15:0]}};
      end
      default: begin
        be   = 4'b1111;
        wdat = cap_dato;
      end
    endcase
  end

  // sin_signo=1 selects zero extension.
  always_comb begin
    desp_byte  = palabra >> {cap_alu[1:0], 3'b000};
    desp_media = palabra >> {cap_alu[1], 4'b0000};
    case (cap_tam)
      2'b00:   carga = cap_sig ? {24'd0, desp_byte[7:0]}
                               : {{24{desp_byte[7]}}, desp_byte[7:0]};
      2'b01:   carga = cap_sig ? {16'd0, desp_media[15:0]}
                               : {{16{desp_media[15]}}, desp_media[15:0]};
      default: carga = palabra;
    endcase
  end

  always_ff @(posedge clk) begin
    if (commit && cap_esc) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[indice][8*i +: 8] <= wdat[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reinicio_n) begin
    if (!reinicio_n) begin
      estado                  <= REPOSO;
      cnt                     <= 4'd0;
      cap_lee                 <= 1'b0;
      cap_esc                 <= 1'b0;
      cap_sig                 <= 1'b0;
      cap_tam                 <= 2'b00;
      cap_alu                 <= 32'd0;
      cap_dato                <= 32'd0;
      cap_rd                  <= 5'd0;
      valido_salida           <= 1'b0;
      resultado_alu_salida    <= 32'd0;
      dato_mem_salida         <= 32'd0;
      registro_destino_salida <= 5'd0;
      error_alineacion        <= 1'b0;
    end else begin
      estado <= estado_sig;
      case (estado)
        REPOSO: begin
          valido_salida    <= 1'b0;
          error_alineacion <= 1'b0;
          if (acepta) begin
            cap_lee  <= lee_mem;
            cap_esc  <= escribe_mem;
            cap_sig  <= sin_signo;
            cap_tam  <= tamano;
            cap_alu  <= resultado_alu_entrada;
            cap_dato <= dato_escritura;
            cap_rd   <= registro_destino_entrada;
            cnt      <= 4'(LATENCIA);
          end else if (valido_entrada) begin
            // Non-memory op, or a rejected misaligned access: one-cycle pass-through.
            valido_salida           <= 1'b1;
            resultado_alu_salida    <= resultado_alu_entrada;
            registro_destino_salida <= registro_destino_entrada;
            dato_mem_salida         <= 32'd0;
            error_alineacion        <= desal;
          end
        end
        ACCESO: begin
          if (cnt == 4'd0) begin
            valido_salida           <= 1'b1;
            resultado_alu_salida    <= cap_alu;
            registro_destino_salida <= cap_rd;
            dato_mem_salida         <= (cap_lee & ~cap_esc) ? carga : 32'd0;
            error_alineacion        <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        FIN:     valido_salida <= 1'b0;
        default: valido_salida <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_etapa_mem.sv
// Self-checking bench for etapa_mem: directed scenarios plus random traffic checked
// against a byte-addressed reference memory.
module tb_etapa_mem;

  localparam int ANCHO_DIR = 10;
  localparam int LATENCIA  = 2;
  localparam int BYTES     = 4 * (2 ** ANCHO_DIR);

  logic        clk, reinicio_n;
  logic        valido_entrada, lee_mem, escribe_mem, sin_signo;
  logic [1:0]  tamano;
  logic [31:0] resultado_alu_entrada, dato_escritura;
  logic [4:0]  registro_destino_entrada;
  logic        detener, valido_salida, error_alineacion;
  logic [31:0] resultado_alu_salida, dato_mem_salida;
  logic [4:0]  registro_destino_salida;
  logic [1:0]  estado_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] dato;
    logic [4:0]  rd;
    logic        err;
    logic [7:0]  lat;
    logic [7:0]  stalls;
    logic        det0;
    logic        strobe_ok;
  } res_t;

  logic [7:0] mb [BYTES];

  etapa_mem #(.ANCHO_DIR(ANCHO_DIR), .LATENCIA(LATENCIA)) dut (
    .clk                      (clk),
    .reinicio_n               (reinicio_n),
    .valido_entrada           (valido_entrada),
    .lee_mem                  (lee_mem),
    .escribe_mem              (escribe_mem),
    .tamano                   (tamano),
    .sin_signo                (sin_signo),
    .resultado_alu_entrada    (resultado_alu_entrada),
    .dato_escritura           (dato_escritura),
    .registro_destino_entrada (registro_destino_entrada),
    .detener                  (detener),
    .valido_salida            (valido_salida),
    .resultado_alu_salida     (resultado_alu_salida),
    .dato_mem_salida          (dato_mem_salida),
    .registro_destino_salida  (registro_destino_salida),
    .error_alineacion         (error_alineacion),
    .estado_dbg               (estado_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: byte-addressed little-endian memory, latency and stall counts from the
  // stage's timing rules (acceptance cycle stalls, then LATENCIA+1 wait cycles).
  task automatic model_op(input logic lee, input logic esc, input logic [1:0] tam,
                          input logic sig, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [4:0] rd, output res_t e);
    int n, base;
    logic [31:0] v;
    e = '0;
    e.alu = addr;
    e.rd = rd;
    e.strobe_ok = 1'b1;
    n = (tam == 2'd0) ? 1 : (tam == 2'd1) ? 2 : 4;
    base = int'(addr % BYTES);
    if (!(lee || esc)) begin
      e.lat = 8'd1;
    end
`ifdef ALINEACION_CHECK_EN
    else if ((base % n) != 0) begin
      e.lat = 8'd1;
      e.err = 1'b1;
    end
`endif
    else begin
      base = base - (base % n);
      e.lat = 8'(LATENCIA + 2);
      e.stalls = 8'(LATENCIA + 1);
      e.det0 = 1'b1;
      if (esc) begin
        for (int i = 0; i < n; i++) mb[base + i] = wdata[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(mb[base + i]) << (8 * i));
        if (!sig && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        e.dato = v;
      end
    end
  endtask

  // Driver: presents one instruction, optionally holds a junk store on the inputs
  // while the access is in progress, and measures what comes back.
  task automatic exec_op(input logic lee, input logic esc, input logic [1:0] tam,
                         input logic sig, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [4:0] rd, input bit junk, output res_t r);
    bit done;
    r = '0;
    done = 0;
    @(negedge clk);
    valido_entrada = 1'b1;
    lee_mem = lee;
    escribe_mem = esc;
    tamano = tam;
    sin_signo = sig;
    resultado_alu_entrada = addr;
    dato_escritura = wdata;
    registro_destino_entrada = rd;
    #1 r.det0 = detener;
    @(posedge clk);
    #1;
    valido_entrada = junk;
    if (junk) begin
      lee_mem = 1'b0;
      escribe_mem = 1'b1;
      tamano = 2'b10;
      resultado_alu_entrada = 32'h3F0;
      dato_escritura = 32'hFFFF_FFFF;
    end
    for (int k = 1; k <= 40 && !done; k++) begin
      @(negedge clk);
      if (detener) r.stalls = r.stalls + 8'd1;
      if (valido_salida) begin
        done = 1;
        r.lat = 8'(k);
        r.alu = resultado_alu_salida;
        r.dato = dato_mem_salida;
        r.rd = registro_destino_salida;
        r.err = error_alineacion;
      end
      if (k >= 2 || done) valido_entrada = 1'b0;
    end
    valido_entrada = 1'b0;
    @(negedge clk);
    r.strobe_ok = done && !valido_salida;
  endtask

  task automatic test_reset();
    reinicio_n = 1'b0;
    valido_entrada = 1'b0;
    lee_mem = 1'b0;
    escribe_mem = 1'b0;
    tamano = 2'b00;
    sin_signo = 1'b0;
    resultado_alu_entrada = 32'd0;
    dato_escritura = 32'd0;
    registro_destino_entrada = 5'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (detener !== 1'b0) begin n_fail++; $display("FAIL reset_detener got %b want 0", detener); end
    n_tests++;
    if (valido_salida !== 1'b0) begin n_fail++; $display("FAIL reset_valido got %b want 0", valido_salida); end
    n_tests++;
    if (resultado_alu_salida !== 32'd0) begin n_fail++; $display("FAIL reset_alu got %h want 0", resultado_alu_salida); end
    n_tests++;
    if (dato_mem_salida !== 32'd0) begin n_fail++; $display("FAIL reset_dato got %h want 0", dato_mem_salida); end
    n_tests++;
    if (registro_destino_salida !== 5'd0) begin n_fail++; $display("FAIL reset_rd got %h want 0", registro_destino_salida); end
    n_tests++;
    if (error_alineacion !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", error_alineacion); end
    n_tests++;
    if (estado_dbg !== 2'd0) begin n_fail++; $display("FAIL reset_estado got %0d want 0", estado_dbg); end
    reinicio_n = 1'b1;
  endtask

  task automatic test_store_load_word();
    res_t r, e;
    model_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 5'd3, e);
    exec_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 5'd3, 1'b0, r);
    n_tests++;
    if (r !== e) begin n_fail++; $display("FAIL store_word got %h want %h", r, e); end
    model_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 5'd4, e);
    exec_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 5'd4, 1'b0, r);
    n_tests++;
    if (r !== e) begin n_fail++; $display("FAIL load_word got %h want %h", r, e); end
    n_tests++;
    if (r.dato !== 32'hDEAD_BEEF || r.stalls !== 8'd3) begin
      n_fail++; $display("FAIL load_word_lit got %h/%0d want deadbeef/3", r.dato, r.stalls);
    end
  endtask

  task automatic test_byte_lanes();
    res_t r, e;
    logic [31:0] lit [3];
    lit[0] = 32'hFFFF_FF80;
    lit[1] = 32'h0000_0080;
    lit[2] = 32'h8022_3344;
    model_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344, 5'd1, e);
    exec_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344, 5'd1, 1'b0, r);
    n_tests++;
    if (r !== e) begin n_fail++; $display("FAIL lanes_init got %h want %h", r, e); end
    model_op(1'b0, 1'b1, 2'b00, 1'b0, 32'h13, 32'hABCD_EF80, 5'd2, e);
    exec_op(1'b0, 1'b1, 2'b00, 1'b0, 32'h13, 32'hABCD_EF80, 5'd2, 1'b0, r);
    n_tests++;
    if (r !== e) begin n_fail++; $display("FAIL lanes_sb got %h want %h", r, e); end
    for (int j = 0; j < 3; j++) begin
      logic [1:0] tam;
      logic sig;
      tam = (j == 2) ? 2'b10 : 2'b00;
      sig = (j == 1);
      model_op(1'b1, 1'b0, tam, sig, (j == 2) ? 32'h10 : 32'h13, 32'd0, 5'd9, e);
      exec_op(1'b1, 1'b0, tam, sig, (j == 2) ? 32'h10 : 32'h13, 32'd0, 5'd9, 1'b0, r);
      n_tests++;
      if (r !== e || r.dato !== lit[j]) begin
        n_fail++; $display("FAIL lanes_load%0d got %h want %h (dato %h)", j, r, e, lit[j]);
      end
    end
  endtask

  task automatic test_passthrough();
    res_t r;
    exec_op(1'b0, 1'b0, 2'b10, 1'b0, 32'h1234, 32'h5555_5555, 5'd7, 1'b0, r);
    n_tests++;
    if (r.lat !== 8'd1 || r.stalls !== 8'd0 || r.det0 !== 1'b0 || !r.strobe_ok) begin
      n_fail++; $display("FAIL pass_timing got lat=%0d stalls=%0d det0=%b want 1/0/0", r.lat, r.stalls, r.det0);
    end
    n_tests++;
    if (r.alu !== 32'h1234 || r.rd !== 5'd7 || r.dato !== 32'd0 || r.err !== 1'b0) begin
      n_fail++; $display("FAIL pass_data got alu=%h rd=%0d dato=%h want 1234/7/0", r.alu, r.rd, r.dato);
    end
  endtask

  task automatic test_reset_mid_access();
    res_t r, e;
    model_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'hA5A5_A5A5, 5'd5, e);
    exec_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'hA5A5_A5A5, 5'd5, 1'b0, r);
    n_tests++;
    if (r !== e) begin n_fail++; $display("FAIL rst_prior got %h want %h", r, e); end
    @(negedge clk);
    valido_entrada = 1'b1;
    lee_mem = 1'b0;
    escribe_mem = 1'b1;
    tamano = 2'b00;
    resultado_alu_entrada = 32'h20;
    dato_escritura = 32'h55;
    registro_destino_entrada = 5'd6;
    @(posedge clk);
    #1 valido_entrada = 1'b0;
    @(negedge clk);
    n_tests++;
    if (detener !== 1'b1) begin n_fail++; $display("FAIL rst_busy got detener=%b want 1", detener); end
    reinicio_n = 1'b0;
    #1;
    n_tests++;
    if ({detener, valido_salida, resultado_alu_salida, dato_mem_salida, registro_destino_salida,
         error_alineacion, estado_dbg} !== '0) begin
      n_fail++; $display("FAIL rst_async got det=%b v=%b alu=%h dato=%h rd=%0d est=%0d want all 0",
                         detener, valido_salida, resultado_alu_salida, dato_mem_salida,
                         registro_destino_salida, estado_dbg);
    end
    @(negedge clk);
    reinicio_n = 1'b1;
    model_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'd0, 5'd8, e);
    exec_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'd0, 5'd8, 1'b0, r);
    n_tests++;
    if (r !== e || r.dato !== 32'hA5A5_A5A5) begin
      n_fail++; $display("FAIL rst_no_store got %h want %h", r, e);
    end
  endtask

  task automatic test_wrap();
    res_t r1, r2, e;
    model_op(1'b1, 1'b0, 2'b01, 1'b1, 32'h22, 32'd0, 5'd10, e);
    exec_op(1'b1, 1'b0, 2'b01, 1'b1, 32'h22, 32'd0, 5'd10, 1'b0, r1);
    n_tests++;
    if (r1 !== e) begin n_fail++; $display("FAIL wrap_low got %h want %h", r1, e); end
    model_op(1'b1, 1'b0, 2'b01, 1'b1, 32'h1022, 32'd0, 5'd10, e);
    exec_op(1'b1, 1'b0, 2'b01, 1'b1, 32'h1022, 32'd0, 5'd10, 1'b0, r2);
    n_tests++;
    if (r2 !== e || r2.dato !== r1.dato) begin
      n_fail++; $display("FAIL wrap_high got %h want %h (low dato %h)", r2, e, r1.dato);
    end
  endtask

  task automatic test_alineacion();
    res_t r, e;
    model_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h21, 32'h7766_5544, 5'd11, e);
    exec_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h21, 32'h7766_5544, 5'd11, 1'b0, r);
    n_tests++;
    if (r !== e) begin n_fail++; $display("FAIL align_store got %h want %h", r, e); end
    model_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'd0, 5'd12, e);
    exec_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'd0, 5'd12, 1'b0, r);
    n_tests++;
`ifdef ALINEACION_CHECK_EN
    if (r !== e || r.dato !== 32'hA5A5_A5A5) begin
`else
    if (r !== e || r.dato !== 32'h7766_5544) begin
`endif
      n_fail++; $display("FAIL align_readback got %h want %h", r, e);
    end
  endtask

  task automatic test_random();
    res_t r, e;
    logic [1:0] kind, tam;
    logic lee, esc, sig;
    logic [31:0] addr, wdata;
    logic [4:0] rd;
    for (int w = 0; w < 16; w++) begin
      wdata = $urandom;
      model_op(1'b0, 1'b1, 2'b10, 1'b0, 32'(w * 4), wdata, 5'd1, e);
      exec_op(1'b0, 1'b1, 2'b10, 1'b0, 32'(w * 4), wdata, 5'd1, 1'b0, r);
      n_tests++;
      if (r !== e) begin n_fail++; $display("FAIL rnd_init%0d got %h want %h", w, r, e); end
    end
    for (int t = 0; t < 60; t++) begin
      kind = 2'($urandom_range(0, 3));
      lee = kind[0];
      esc = kind[1];
      tam = 2'($urandom_range(0, 3));
      sig = 1'($urandom_range(0, 1));
      addr = (32'($urandom_range(0, 1023)) << 12) | 32'($urandom_range(0, 63));
      wdata = $urandom;
      rd = 5'($urandom_range(0, 31));
      model_op(lee, esc, tam, sig, addr, wdata, rd, e);
      exec_op(lee, esc, tam, sig, addr, wdata, rd, 1'b0, r);
      n_tests++;
      if (r !== e) begin
        n_fail++; $display("FAIL rnd%0d op=%0d tam=%0d addr=%h got %h want %h", t, kind, tam, addr, r, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    res_t r, e;
    logic [31:0] addr, wdata;
    model_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h3F0, 32'h1234_5678, 5'd2, e);
    exec_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h3F0, 32'h1234_5678, 5'd2, 1'b0, r);
    n_tests++;
    if (r !== e) begin n_fail++; $display("FAIL b2b_init got %h want %h", r, e); end
    for (int t = 0; t < 6; t++) begin
      addr = 32'($urandom_range(0, 15)) * 4;
      wdata = $urandom;
      model_op(t[0], ~t[0], 2'b10, 1'b0, addr, wdata, 5'(t), e);
      exec_op(t[0], ~t[0], 2'b10, 1'b0, addr, wdata, 5'(t), 1'b1, r);
      n_tests++;
      if (r !== e) begin n_fail++; $display("FAIL b2b%0d got %h want %h", t, r, e); end
    end
    model_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h3F0, 32'd0, 5'd3, e);
    exec_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h3F0, 32'd0, 5'd3, 1'b0, r);
    n_tests++;
    if (r !== e || r.dato !== 32'h1234_5678) begin
      n_fail++; $display("FAIL b2b_ignored got %h want %h", r, e);
    end
  endtask

  initial begin
    test_reset();
    test_store_load_word();
    test_byte_lanes();
    test_passthrough();
    test_reset_mid_access();
    test_wrap();
    test_alineacion();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
